// File: rtl/counter_checker_pkg.sv
// Shared definitions for the free-running counter checker: state encoding and
// datapath widths.
package counter_checker_pkg;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam int CNT_W  = 8;
  localparam int WRAP_W = 16;
  localparam int RUN_W  = 4;

  localparam logic [CNT_W-1:0] ERR_MAX = '1;

endpackage

// File: rtl/counter_checker.sv
// Watches an externally produced 8-bit free-running counter and its wrap flag,
// locks onto it after LOCK_COUNT consecutive good samples and counts faults.
module counter_checker
  import counter_checker_pkg::*;
#(
  parameter int LOCK_COUNT = 4
) (
  input  logic              system_clock_in,
  input  logic              system_reset,
  input  logic [CNT_W-1:0]  counter_in,
  input  logic              counter_zero_in,
  input  logic              clear_errors,
  output logic              locked,
  output logic              error_pulse,
  output logic [CNT_W-1:0]  error_count,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              led
);

  logic [CNT_W-1:0]  r_sample;
  logic              r_sample_zero;
  logic              r_sample_valid;
  logic [CNT_W-1:0]  r_prev;
  logic              r_prev_valid;

  state_e            r_state;
  logic [RUN_W-1:0]  r_run_count;
  logic              r_error_pulse;
  logic [CNT_W-1:0]  r_error_count;
  logic              r_error_sticky;
  logic [WRAP_W-1:0] r_wrap_count;

  logic              w_next_ok;
  logic              w_flag_ok;
  logic              w_good;
  logic              w_sample_is_zero;

  // Sample stage: r_sample_valid marks that r_sample holds a real capture, and
  // r_prev_valid lags it so the first capture after reset has no predecessor.
  always_ff @(posedge system_clock_in or negedge system_reset) begin
    if (!system_reset) begin
      r_sample       <= '0;
      r_sample_zero  <= 1'b0;
      r_sample_valid <= 1'b0;
      r_prev         <= '0;
      r_prev_valid   <= 1'b0;
    end else begin
      r_sample       <= counter_in;
      r_sample_zero  <= counter_zero_in;
      r_sample_valid <= 1'b1;
      r_prev         <= r_sample;
      r_prev_valid   <= r_sample_valid;
    end
  end

  assign w_sample_is_zero = (r_sample == '0);
  assign w_next_ok        = (r_sample == CNT_W'(r_prev + 1'b1));
  assign w_flag_ok        = (r_sample_zero == w_sample_is_zero);
  assign w_good           = r_prev_valid && w_next_ok && w_flag_ok;

  // Judge stage; clear_errors is applied last so it overrides a fault counted
  // on the same edge, while the pulse and the drop to HUNT still happen.
  always_ff @(posedge system_clock_in or negedge system_reset) begin
    if (!system_reset) begin
      r_state        <= ST_HUNT;
      r_run_count    <= '0;
      r_error_pulse  <= 1'b0;
      r_error_count  <= '0;
      r_error_sticky <= 1'b0;
      r_wrap_count   <= '0;
    end else begin
      r_error_pulse <= 1'b0;
      if (r_sample_valid) begin
        case (r_state)
          ST_HUNT: begin
            if (!w_good) begin
              r_run_count <= '0;
            end else if (r_run_count == RUN_W'(LOCK_COUNT - 1)) begin
              r_state     <= ST_LOCKED;
              r_run_count <= '0;
            end else begin
              r_run_count <= r_run_count + 1'b1;
            end
          end
          ST_LOCKED: begin
            if (w_good) begin
              if (w_sample_is_zero) begin
                r_wrap_count <= r_wrap_count + 1'b1;
              end
            end else begin
              r_state        <= ST_HUNT;
              r_run_count    <= '0;
              r_error_pulse  <= 1'b1;
              r_error_sticky <= 1'b1;
              if (r_error_count != ERR_MAX) begin
                r_error_count <= r_error_count + 1'b1;
              end
            end
          end
          default: begin
            r_state     <= ST_HUNT;
            r_run_count <= '0;
          end
        endcase
      end
      if (clear_errors) begin
        r_error_count  <= '0;
        r_error_sticky <= 1'b0;
      end
    end
  end

  assign locked      = (r_state == ST_LOCKED);
  assign error_pulse = r_error_pulse;
  assign error_count = r_error_count;
  assign wrap_count  = r_wrap_count;
  assign led         = locked && !r_error_sticky;

endmodule

// File: tb/tb_counter_checker.sv
// Randomized bench for counter_checker: a sample-level reference model tracks
// the expected outputs two cycles behind the driven stream.
module tb_counter_checker;

  localparam int LOCK_COUNT = 4;

  logic        clk;
  logic        system_reset;
  logic [7:0]  counter_in;
  logic        counter_zero_in;
  logic        clear_errors;
  logic        locked;
  logic        error_pulse;
  logic [7:0]  error_count;
  logic [15:0] wrap_count;
  logic        led;

  int n_checks = 0;
  int n_fail   = 0;

  counter_checker #(.LOCK_COUNT(LOCK_COUNT)) dut (
    .system_clock_in (clk),
    .system_reset    (system_reset),
    .counter_in      (counter_in),
    .counter_zero_in (counter_zero_in),
    .clear_errors    (clear_errors),
    .locked          (locked),
    .error_pulse     (error_pulse),
    .error_count     (error_count),
    .wrap_count      (wrap_count),
    .led             (led)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [7:0] pipe_v[$];
  logic       pipe_z[$];
  logic       last_clr;
  int         m_prev;
  bit         m_have_prev;
  bit         m_locked;
  int         m_run;
  int         m_err;
  bit         m_sticky;
  int         m_wraps;
  bit         m_pulse;
  logic [7:0] cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pipe_v.delete();
    pipe_z.delete();
    last_clr    = 1'b0;
    m_prev      = 0;
    m_have_prev = 0;
    m_locked    = 0;
    m_run       = 0;
    m_err       = 0;
    m_sticky    = 0;
    m_wraps     = 0;
    m_pulse     = 0;
  endtask

  task automatic model_apply(input int v, input bit z, input bit has_sample, input bit clr);
    bit good;
    m_pulse = 0;
    if (has_sample) begin
      good = m_have_prev && (v == (m_prev + 1) % 256) && (z == (v == 0));
      if (m_locked) begin
        if (good) begin
          if (v == 0) m_wraps = (m_wraps + 1) % 65536;
        end else begin
          m_pulse  = 1;
          m_locked = 0;
          m_run    = 0;
          if (m_err < 255) m_err++;
          m_sticky = 1;
        end
      end else if (good) begin
        m_run++;
        if (m_run == LOCK_COUNT) begin
          m_locked = 1;
          m_run    = 0;
        end
      end else begin
        m_run = 0;
      end
      m_prev      = v;
      m_have_prev = 1;
    end
    if (clr) begin
      m_err    = 0;
      m_sticky = 0;
    end
  endtask

  task automatic compare_all();
    check("locked", {31'd0, locked}, {31'd0, m_locked});
    check("pulse", {31'd0, error_pulse}, {31'd0, m_pulse});
    check("err_cnt", {24'd0, error_count}, m_err);
    check("wraps", {16'd0, wrap_count}, m_wraps);
    check("led", {31'd0, led}, {31'd0, m_locked && !m_sticky});
  endtask

  // driver: called at a falling edge; advances the model, compares, drives
  task automatic step(input logic [7:0] v, input logic z, input logic clr);
    logic [7:0] pv;
    logic       pz;
    if (pipe_v.size() == 2) begin
      pv = pipe_v.pop_front();
      pz = pipe_z.pop_front();
      model_apply(int'(pv), pz, 1'b1, last_clr);
    end else begin
      model_apply(0, 1'b0, 1'b0, last_clr);
    end
    compare_all();
    counter_in      = v;
    counter_zero_in = z;
    clear_errors    = clr;
    pipe_v.push_back(v);
    pipe_z.push_back(z);
    last_clr = clr;
    @(negedge clk);
  endtask

  task automatic good_run(input int n);
    for (int i = 0; i < n; i++) begin
      step(cnt, cnt == 8'd0, 1'b0);
      cnt = cnt + 8'd1;
    end
  endtask

  task automatic fault_skip();
    cnt = cnt + 8'd1;
    step(cnt, cnt == 8'd0, 1'b0);
    cnt = cnt + 8'd1;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    system_reset    = 1'b0;
    counter_in      = 8'd0;
    counter_zero_in = 1'b0;
    clear_errors    = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    compare_all();
    system_reset = 1'b1;
  endtask

  initial begin
    system_reset    = 1'b0;
    counter_in      = 8'd0;
    counter_zero_in = 1'b0;
    clear_errors    = 1'b0;
    model_reset();

    // ideal counter from a random start: lock two cycles after the 5th sample
    hold_reset();
    cnt = 8'($urandom_range(0, 255));
    good_run(5);
    check("no_early_lock", {31'd0, locked}, 32'd0);
    good_run(1);
    check("lock_rise", {31'd0, locked}, 32'd1);
    check("lock_err0", {24'd0, error_count}, 32'd0);
    good_run(4);

    // skip fault 10,11,13 while locked, then relock
    hold_reset();
    cnt = 8'd2;
    good_run(10);
    fault_skip();
    good_run(1);
    check("skip_pulse", {31'd0, error_pulse}, 32'd1);
    check("skip_unlock", {31'd0, locked}, 32'd0);
    check("skip_err", {24'd0, error_count}, 32'd1);
    check("skip_led", {31'd0, led}, 32'd0);
    good_run(3);
    good_run(2);
    check("relock", {31'd0, locked}, 32'd1);

    // wrap flag raised on a nonzero value, then a correct 255->0 wrap
    while (cnt != 8'd7) good_run(1);
    step(8'd7, 1'b1, 1'b0);
    cnt = 8'd8;
    good_run(1);
    check("flag_err", {24'd0, error_count}, 32'd2);
    check("flag_unlock", {31'd0, locked}, 32'd0);
    check("wrap_pre", {16'd0, wrap_count}, 32'd1);
    while (cnt != 8'd3) good_run(1);
    check("wrap_post", {16'd0, wrap_count}, 32'd2);

    // 300 faults with relock in between: error_count saturates
    for (int f = 0; f < 300; f++) begin
      fault_skip();
      good_run(5);
    end
    check("err_sat", {24'd0, error_count}, 32'd255);

    // clear_errors coincident with a fault
    cnt = cnt + 8'd1;
    step(cnt, cnt == 8'd0, 1'b0);
    cnt = cnt + 8'd1;
    step(cnt, cnt == 8'd0, 1'b1);
    cnt = cnt + 8'd1;
    check("clr_pulse", {31'd0, error_pulse}, 32'd1);
    check("clr_err", {24'd0, error_count}, 32'd0);
    check("clr_unlock", {31'd0, locked}, 32'd0);
    good_run(5);
    check("clr_relock", {31'd0, locked}, 32'd1);
    check("clr_led", {31'd0, led}, 32'd1);

    // asynchronous reset between edges while locked
    @(posedge clk);
    #2;
    system_reset = 1'b0;
    #1;
    check("arst_locked", {31'd0, locked}, 32'd0);
    check("arst_pulse", {31'd0, error_pulse}, 32'd0);
    check("arst_err", {24'd0, error_count}, 32'd0);
    check("arst_wraps", {16'd0, wrap_count}, 32'd0);
    check("arst_led", {31'd0, led}, 32'd0);
    @(negedge clk);
    model_reset();
    system_reset = 1'b1;
    check("arst_hold", {31'd0, locked}, 32'd0);
    for (int i = 0; i < LOCK_COUNT + 1; i++) begin
      good_run(1);
      check("arst_hold", {31'd0, locked}, 32'd0);
    end
    good_run(3);

    // random data never locks and never counts errors
    hold_reset();
    for (int i = 0; i < 1000; i++) begin
      step(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
      check("rand_locked", {31'd0, locked}, 32'd0);
    end
    check("rand_err", {24'd0, error_count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
